// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: opcode/funct encodings,
// FSM state type and the per-instruction completion-class record.
package fetch_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP1    = 6'b010001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_LWC1    = 6'b110001;
    localparam logic [5:0] OP_LWC2    = 6'b110010;
    localparam logic [5:0] OP_SWC1    = 6'b111001;
    localparam logic [5:0] OP_SWC2    = 6'b111010;
    localparam logic [5:0] OP_OUT     = 6'b111111;

    localparam logic [5:0] FUNC_JR      = 6'b001000;

    localparam logic [5:0] FLOAT_ADD    = 6'b000000;
    localparam logic [5:0] FLOAT_SUB    = 6'b000001;
    localparam logic [5:0] FLOAT_MUL    = 6'b000010;
    localparam logic [5:0] FLOAT_DIV    = 6'b000011;
    localparam logic [5:0] FLOAT_SQRT   = 6'b000100;
    localparam logic [5:0] FLOAT_ABS    = 6'b000101;
    localparam logic [5:0] FLOAT_ROUNDW = 6'b001100;
    localparam logic [5:0] FLOAT_MFC1   = 6'b010000;
    localparam logic [5:0] FLOAT_MFC2   = 6'b010001;
    localparam logic [5:0] FLOAT_CVTSW  = 6'b100000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATWAIT = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_HALT    = 3'd5
    } fetch_state_t;

    typedef struct packed {
        logic pc;
        logic wb;
        logic st;
        logic io;
    } need_t;

    function automatic logic is_out(input logic [5:0] opcode);
        return (opcode == OP_OUT);
    endfunction

endpackage

// File: rtl/fetch_classify.sv
// Combinational class table: which completion pulses an instruction produces.
module fetch_classify
    import fetch_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output need_t      need
);

    // Decode opcode/funct into the set of finish pulses to wait for
    always_comb begin
        need    = '{pc: 1'b1, wb: 1'b0, st: 1'b0, io: 1'b0};
        case (opcode)
            OP_SPECIAL: begin
                if (funct != FUNC_JR) begin
                    need.wb = 1'b1;
                end else begin
                    need.wb = 1'b0;
                end
            end
            OP_ADDI, OP_SLTI, OP_LUI, OP_LW, OP_LWC1, OP_JAL: begin
                need.wb = 1'b1;
            end
            OP_COP1: begin
                // Compares occupy the 11xxxx funct block
                if (funct[5:4] == 2'b11) begin
                    need.wb = 1'b1;
                end else begin
                    case (funct)
                        FLOAT_ADD, FLOAT_SUB, FLOAT_MUL, FLOAT_DIV,
                        FLOAT_SQRT, FLOAT_ABS, FLOAT_ROUNDW, FLOAT_CVTSW,
                        FLOAT_MFC1, FLOAT_MFC2: need.wb = 1'b1;
                        default:                need.wb = 1'b0;
                    endcase
                end
            end
            OP_SW, OP_SWC1: begin
                need.st = 1'b1;
            end
            OP_LWC2, OP_SWC2: begin
                need.io = 1'b1;
            end
            default: begin
                need = '{pc: 1'b1, wb: 1'b0, st: 1'b0, io: 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: fetch, wait BRAM latency, issue, await completion.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int IMEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       op,
    output logic              d_valid,
    input  logic              write_finish,
    input  logic              store_finish,
    input  logic              jump_finish,
    input  logic              io_finish,
    output logic              busy,
    output logic              halted,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
);

    localparam logic [2:0] LAT_LOAD = 3'(IMEM_LAT - 1);

    fetch_state_t      state_r;
    fetch_state_t      next_state_s;
    logic [2:0]        lat_cnt_r;
    logic [31:0]       op_r;
    logic [ADDR_W-1:0] addr_r;
    need_t             need_r;
    need_t             got_r;
    need_t             need_s;
    need_t             fin_s;
    need_t             got_now_s;
    logic              done_s;

    fetch_classify u_classify (
        .opcode (op_r[31:26]),
        .funct  (op_r[5:0]),
        .need   (need_s)
    );

    // Gather this cycle's finish pulses and test for completion
    always_comb begin
        fin_s     = '{pc: jump_finish, wb: write_finish, st: store_finish, io: io_finish};
        got_now_s = got_r | fin_s;
        done_s    = ((got_now_s & need_r) == need_r);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_FETCH;
                else       next_state_s = ST_IDLE;
            end
            ST_FETCH: begin
                next_state_s = ST_LATWAIT;
            end
            ST_LATWAIT: begin
                if (lat_cnt_r == 3'd0) next_state_s = ST_ISSUE;
                else                   next_state_s = ST_LATWAIT;
            end
            ST_ISSUE: begin
                if (is_out(op_r[31:26])) next_state_s = ST_HALT;
                else                     next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_s) next_state_s = ST_FETCH;
                else        next_state_s = ST_WAIT;
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: latency counter, op capture, address hold, need/got flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_r <= 3'd0;
            op_r      <= 32'd0;
            addr_r    <= '0;
            need_r    <= '0;
            got_r     <= '0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    lat_cnt_r <= LAT_LOAD;
                    addr_r    <= pc_addr;
                end
                ST_LATWAIT: begin
                    if (lat_cnt_r == 3'd0) begin
                        op_r <= imem_data;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                ST_ISSUE: begin
                    // Pulses coincident with issue already count toward completion
                    need_r <= need_s;
                    got_r  <= fin_s;
                end
                ST_WAIT: begin
                    got_r <= got_now_s;
                end
                default: begin
                    lat_cnt_r <= lat_cnt_r;
                end
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        imem_en   = 1'b0;
        imem_addr = addr_r;
        d_valid   = 1'b0;
        busy      = (state_r != ST_IDLE) && (state_r != ST_HALT);
        halted    = (state_r == ST_HALT);
        op        = op_r;
        case (state_r)
            ST_FETCH: begin
                imem_en   = 1'b1;
                imem_addr = pc_addr;
            end
            ST_ISSUE: begin
                d_valid = 1'b1;
            end
            default: begin
                imem_en = 1'b0;
            end
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] retired_r;
    logic [31:0] stall_r;

    // Retirement and wait-cycle counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= 32'd0;
            stall_r   <= 32'd0;
        end else begin
            if ((state_r == ST_WAIT && done_s) ||
                (state_r == ST_ISSUE && is_out(op_r[31:26]))) begin
                retired_r <= retired_r + 32'd1;
            end else begin
                retired_r <= retired_r;
            end
            if (state_r == ST_WAIT) begin
                stall_r <= stall_r + 32'd1;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    assign retired_cnt = retired_r;
    assign stall_cnt   = stall_r;
`else
    assign retired_cnt = 32'd0;
    assign stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a pipelined BRAM model.
module tb_fetch_ctrl;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pc_addr;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   op;
    logic          d_valid;
    logic          write_finish, store_finish, jump_finish, io_finish;
    logic          busy, halted;
    logic [31:0]   retired_cnt, stall_cnt;

    logic [31:0]   imem [0:15];
    logic [31:0]   pipe [0:LAT-1];

    int n_cmp  = 0;
    int n_fail = 0;
    int en_seen;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(AW), .IMEM_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pc_addr      (pc_addr),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .op           (op),
        .d_valid      (d_valid),
        .write_finish (write_finish),
        .store_finish (store_finish),
        .jump_finish  (jump_finish),
        .io_finish    (io_finish),
        .busy         (busy),
        .halted       (halted),
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
    );

    // BRAM model: read data appears LAT cycles after the enable cycle
    always_ff @(posedge clk) begin
        pipe[0] <= imem_en ? imem[imem_addr[3:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign imem_data = pipe[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_issue(input logic [31:0] exp_op);
        for (int i = 0; i < 8 && !d_valid; i++) begin
            tick();
            start = 1'b0;
        end
        check_eq("issue_pulse", {31'd0, d_valid}, 32'd1);
        check_eq("issue_op", op, exp_op);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc_addr = '0;
        write_finish = 1'b0; store_finish = 1'b0; jump_finish = 1'b0; io_finish = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 32'd0;
        imem[0] = 32'h2022_0005;  // ADDI
        imem[1] = 32'hAC22_0004;  // SW
        imem[2] = 32'h1022_0003;  // BEQ
        imem[3] = 32'hFC00_0000;  // OUT
        imem[4] = 32'hE800_0000;  // SWC2
        imem[5] = 32'h2022_0001;
        imem[6] = 32'h2022_0002;
        imem[7] = 32'h2022_0003;
        imem[8] = 32'hFC00_0000;

        do_reset();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_op", op, 32'd0);
        check_eq("rst_en", {31'd0, imem_en}, 32'd0);

        // 1: ADDI
        start = 1'b1;                                         // c0
        tick(); start = 1'b0;                                 // c1
        check_eq("t1_en", {31'd0, imem_en}, 32'd1);
        check_eq("t1_addr", 32'(imem_addr), 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        tick();                                               // c2
        check_eq("t1_en_off", {31'd0, imem_en}, 32'd0);
        tick();                                               // c3
        check_eq("t1_op_pre", op, 32'd0);
        check_eq("t1_dv_pre", {31'd0, d_valid}, 32'd0);
        tick();                                               // c4
        check_eq("t1_dv", {31'd0, d_valid}, 32'd1);
        check_eq("t1_op", op, 32'h2022_0005);
        tick();                                               // c5
        check_eq("t1_dv_once", {31'd0, d_valid}, 32'd0);
        tick(); tick(); write_finish = 1'b1;                  // c7
        tick(); write_finish = 1'b0;                          // c8
        tick(); jump_finish = 1'b1;                           // c9
        check_eq("t1_wait", {31'd0, imem_en}, 32'd0);
        pc_addr = 10'd1;
        tick(); jump_finish = 1'b0;                           // c10
        check_eq("t1_refetch", {31'd0, imem_en}, 32'd1);
        check_eq("t1_addr2", 32'(imem_addr), 32'd1);

        // 2: SW needs store; write pulse must not complete it
        run_to_issue(32'hAC22_0004);
        tick(); jump_finish = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); jump_finish = 1'b0;
            write_finish = (i == 1);
            store_finish = (i == 3);
            check_eq("t2_hold", {31'd0, imem_en}, 32'd0);
        end
        pc_addr = 10'd2;
        tick(); store_finish = 1'b0; write_finish = 1'b0;
        check_eq("t2_refetch", {31'd0, imem_en}, 32'd1);
        check_eq("t2_addr", 32'(imem_addr), 32'd2);

        // 3: BEQ, jump pulse on the first WAIT cycle, new pc used in FETCH
        run_to_issue(32'h1022_0003);
        tick(); jump_finish = 1'b1; pc_addr = 10'd3;
        tick(); jump_finish = 1'b0;
        check_eq("t3_refetch", {31'd0, imem_en}, 32'd1);
        check_eq("t3_addr", 32'(imem_addr), 32'd3);

        // 4: OUT halts
        run_to_issue(32'hFC00_0000);
        tick();
        check_eq("t4_dv", {31'd0, d_valid}, 32'd0);
        check_eq("t4_halted", {31'd0, halted}, 32'd1);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            start = i[0]; jump_finish = i[1]; write_finish = i[2];
            tick();
            if (imem_en) en_seen++;
        end
        start = 1'b0; jump_finish = 1'b0; write_finish = 1'b0;
        check_eq("t4_no_fetch", 32'(en_seen), 32'd0);
        check_eq("t4_still_halted", {31'd0, halted}, 32'd1);

        // 5: async reset mid-WAIT of SWC2
        do_reset();
        pc_addr = 10'd4; start = 1'b1;
        tick();
        run_to_issue(32'hE800_0000);
        tick(); tick();
        check_eq("t5_waiting", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_async_op", op, 32'd0);
        check_eq("t5_async_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_async_addr", 32'(imem_addr), 32'd0);
        check_eq("t5_async_flags", {29'd0, d_valid, imem_en, halted}, 32'd0);
        tick(); rst = 1'b0;
        tick(); io_finish = 1'b1;
        tick(); io_finish = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_en || busy) en_seen++;
        end
        check_eq("t5_idle", 32'(en_seen), 32'd0);

        // 6: performance counters
        do_reset();
        check_eq("t6_ret0", retired_cnt, 32'd0);
        check_eq("t6_stall0", stall_cnt, 32'd0);
        pc_addr = 10'd5; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_to_issue(32'h2022_0001 + 32'(k));
            tick();                                           // WAIT 1
            tick(); write_finish = 1'b1; jump_finish = 1'b1;  // WAIT 2
            pc_addr = 10'(6 + k);
            tick(); write_finish = 1'b0; jump_finish = 1'b0;  // FETCH
        end
        run_to_issue(32'hFC00_0000);
        tick(); tick();
        check_eq("t6_halted", {31'd0, halted}, 32'd1);
`ifdef FETCH_CTRL_PERF_EN
        check_eq("t6_retired", retired_cnt, 32'd4);
        check_eq("t6_stall", stall_cnt, 32'd6);
`else
        check_eq("t6_retired", retired_cnt, 32'd0);
        check_eq("t6_stall", stall_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
